// File: rtl/pair_collector_if.sv
// rtl/pair_collector_if.sv - word-in / pair-out handshake bundle for pair_collector
interface pair_collector_if #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_a;
  logic [WIDTH-1:0]   out_b;
  logic               out_partial;
  logic [COUNT_W-1:0] pair_count;

  // Block side: consumes words, produces pairs.
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_partial, pair_count
  );

  // Environment side: supplies words, takes pairs.
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_partial, pair_count
  );
endinterface

// File: rtl/pair_collector.sv
// rtl/pair_collector.sv - groups a word stream into (a, b) pairs, flush closes a lone word
module pair_collector #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pair_collector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t state;
  logic   accept;
  logic   pop;

  // A held pair blocks new words unless it leaves on this same edge.
  assign bus.in_ready = (state != FULL) | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = bus.out_valid & bus.out_ready;

  // Pair-building FSM; every output except in_ready is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.out_valid   <= 1'b0;
      bus.out_a       <= {WIDTH{1'b0}};
      bus.out_b       <= {WIDTH{1'b0}};
      bus.out_partial <= 1'b0;
      bus.pair_count  <= {COUNT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          // A flush with nothing held has nothing to close.
          if (accept) begin
            bus.out_a <= bus.in_data;
            state     <= HALF;
          end
        end
        HALF: begin
          // A real second word beats a flush arriving on the same edge.
          if (accept) begin
            bus.out_b       <= bus.in_data;
            bus.out_partial <= 1'b0;
            bus.out_valid   <= 1'b1;
            state           <= FULL;
          end else if (bus.flush) begin
            bus.out_b       <= {WIDTH{1'b0}};
            bus.out_partial <= 1'b1;
            bus.out_valid   <= 1'b1;
            state           <= FULL;
          end
        end
        FULL: begin
          // Without a pop everything holds; accept implies pop here.
          if (pop) begin
            bus.pair_count <= bus.pair_count + COUNT_W'(1);
            bus.out_valid  <= 1'b0;
            if (accept) begin
              bus.out_a <= bus.in_data;
              state     <= HALF;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_collector.sv
// tb/tb_pair_collector.sv - directed and random checks of pair_collector against a word-level model
module tb_pair_collector;

  localparam int W  = 32;
  localparam int CW = 4;

  logic clk;
  logic rst_n;

  pair_collector_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

  pair_collector #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: words waiting for a partner, plus the pair on offer.
  logic [W-1:0] lone[$];
  bit           m_valid;
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  bit           exp_p;
  int           m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    lone.delete();
    m_valid = 0;
    exp_a   = '0;
    exp_b   = '0;
    exp_p   = 0;
    m_cnt   = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ":out_valid"},   64'(bus.out_valid),   64'(m_valid));
    chk({where, ":out_a"},       64'(bus.out_a),       64'(exp_a));
    chk({where, ":out_b"},       64'(bus.out_b),       64'(exp_b));
    chk({where, ":out_partial"}, 64'(bus.out_partial), 64'(exp_p));
    chk({where, ":pair_count"},  64'(bus.pair_count),  64'(m_cnt % (1 << CW)));
  endtask

  // One clock: drive at posedge+1, check in_ready, clock, update model, check outputs.
  task automatic step(input bit v, input logic [W-1:0] d, input bit f, input bit r);
    bit exp_ready;
    bit acc;
    bit pop;
    bit was_half;
    bus.in_valid  = v;
    bus.in_data   = v ? d : 'x;
    bus.flush     = f;
    bus.out_ready = r;
    #1;
    exp_ready = !m_valid || r;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    @(posedge clk);
    acc      = v && exp_ready;
    pop      = m_valid && r;
    was_half = (lone.size() == 1);
    if (pop) begin
      m_valid = 0;
      m_cnt   = m_cnt + 1;
    end
    if (acc) begin
      if (lone.size() == 0) begin
        lone.push_back(d);
        exp_a = d;
      end else begin
        exp_b   = d;
        exp_p   = 0;
        m_valid = 1;
        lone.delete();
      end
    end else if (f && was_half) begin
      exp_b   = '0;
      exp_p   = 1;
      m_valid = 1;
      lone.delete();
    end
    #1;
    check_all("step");
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid",   64'(bus.out_valid),   64'd0);
    chk("rst_out_a",       64'(bus.out_a),       64'd0);
    chk("rst_out_b",       64'(bus.out_b),       64'd0);
    chk("rst_out_partial", 64'(bus.out_partial), 64'd0);
    chk("rst_pair_count",  64'(bus.pair_count),  64'd0);
    chk("rst_in_ready",    64'(bus.in_ready),    64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    #1;

    // Reset from an unknown start.
    mid_reset();

    // Basic pair.
    step(1, 32'd30, 0, 1);
    step(1, 32'd20, 0, 1);
    chk("basic_valid", 64'(bus.out_valid), 64'd1);
    chk("basic_a", 64'(bus.out_a), 64'd30);
    chk("basic_b", 64'(bus.out_b), 64'd20);
    chk("basic_partial", 64'(bus.out_partial), 64'd0);
    step(0, '0, 0, 1);
    chk("basic_count", 64'(bus.pair_count), 64'd1);
    chk("basic_idle", 64'(bus.out_valid), 64'd0);

    // Backpressure, then pop and refill on one edge.
    step(1, 32'd1, 0, 0);
    step(1, 32'd2, 0, 0);
    step(1, 32'd3, 0, 0);
    chk("bp_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_a", 64'(bus.out_a), 64'd1);
    chk("bp_b", 64'(bus.out_b), 64'd2);
    step(1, 32'd3, 0, 1);
    chk("refill_valid", 64'(bus.out_valid), 64'd0);
    chk("refill_a", 64'(bus.out_a), 64'd3);
    step(1, 32'd4, 0, 1);
    step(0, '0, 0, 1);

    // Flush closes a lone word; flush in IDLE does nothing.
    step(1, 32'd7, 0, 0);
    step(0, '0, 1, 0);
    chk("flush_a", 64'(bus.out_a), 64'd7);
    chk("flush_b", 64'(bus.out_b), 64'd0);
    chk("flush_partial", 64'(bus.out_partial), 64'd1);
    chk("flush_valid", 64'(bus.out_valid), 64'd1);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    step(0, '0, 1, 1);
    chk("idle_flush_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_flush_count", 64'(bus.pair_count), 64'd4);

    // Accept and flush together in HALF: a normal pair.
    step(1, 32'd5, 0, 0);
    step(1, 32'd9, 1, 0);
    chk("accfl_a", 64'(bus.out_a), 64'd5);
    chk("accfl_b", 64'(bus.out_b), 64'd9);
    chk("accfl_partial", 64'(bus.out_partial), 64'd0);
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    chk("accfl_no_extra", 64'(bus.out_valid), 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 2) != 0));
    end
    step(0, '0, 1, 1);
    step(0, '0, 0, 1);

    // Counter wrap from a clean start, sustained one word per cycle.
    mid_reset();
    for (int i = 0; i < 32; i++) begin
      step(1, 32'(i + 100), 0, 1);
      if (i == 30) chk("wrap_15", 64'(bus.pair_count), 64'd15);
    end
    step(0, '0, 0, 1);
    chk("wrap_zero", 64'(bus.pair_count), 64'd0);

    // Reset while holding a lone word.
    step(1, 32'd77, 0, 1);
    mid_reset();
    step(1, 32'd4, 0, 0);
    step(1, 32'd6, 0, 0);
    chk("postrst_a", 64'(bus.out_a), 64'd4);
    chk("postrst_b", 64'(bus.out_b), 64'd6);
    chk("postrst_valid", 64'(bus.out_valid), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pair_collector.md
Name: pair_collector

Overview:
- Upstream feeder for the two-operand swap stage.
- Accepts a serial stream of WIDTH-bit words on a valid/ready handshake and groups consecutive words into (a, b) pairs.
- Presents each pair on a registered output with valid/ready.
- A flush input closes out an odd trailing word as a partial pair.

Parameters:
WIDTH, 32, bit width of each data word and of out_a/out_b
COUNT_W, 16, width of the completed-pair counter

Ports:
clk  input  1  clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  upstream word
flush  input  1  emit a held lone word as a partial pair
out_valid  output  1  pair on out_a/out_b is valid
out_ready  input  1  downstream (swap stage) accepts the pair
out_a  output  WIDTH  first word of the pair
out_b  output  WIDTH  second word of the pair (0 when partial)
out_partial  output  1  pair was closed by flush; out_b is filler
pair_count  output  COUNT_W  number of pairs popped since reset

Behaviour:
- Reset and clocking:
  - Interface as decided: one clock (clk); reset is asynchronous and active-low (rst_n).
  - Reset asserted at any time, including mid-pair or with a pair pending, takes effect immediately.
  - Reset values: state=IDLE, out_valid=0, out_a=0, out_b=0, out_partial=0, pair_count=0.
  - Held words are discarded on reset.
- Handshakes:
  - A word is accepted when in_valid & in_ready at a rising edge.
  - A pair is popped when out_valid & out_ready at a rising edge.
- States:
  - IDLE: nothing held.
  - HALF: out_a holds the first word.
  - FULL: pair held, out_valid=1.
- out_valid is a registered output, equal to (state==FULL).
- in_ready = (state!=FULL) | out_ready. This is combinational from out_ready, and is the only comb path through the block.
- Transitions:
  - IDLE, accept: out_a<=in_data, go to HALF. Flush in IDLE is ignored (no output).
  - HALF, accept: out_b<=in_data, out_partial<=0, go to FULL.
  - HALF, flush without accept: out_b<=0, out_partial<=1, go to FULL.
  - HALF, accept and flush in the same cycle: accept wins, a normal pair is formed, and the flush is dropped.
  - FULL, pop without accept: go to IDLE.
  - FULL, pop with accept: out_a<=in_data, go to HALF. Pop and refill happen in the same edge.
  - FULL, no pop: hold all outputs stable; in_ready=0; flush is ignored.
- Data ordering: the first word accepted is always out_a and the second is out_b. The block never swaps; swapping is downstream.
- Latency: a second word accepted at edge N gives out_valid=1 from edge N (visible in cycle N+1).
- Throughput: max one pair per two cycles, i.e. one word per cycle sustained with out_ready=1.
- pair_count:
  - Increments by 1 on every pop, partial pairs included.
  - Wraps from 2^COUNT_W-1 to 0 with no saturation.
- out_a/out_b/out_partial change only on the edges listed above and are stable while out_valid=1 and out_ready=0.
- X on in_data while in_valid=0 must not propagate into held state.

Test Plan:
1. Reset: assert rst_n=0 mid-clock -> immediately out_valid=0, out_a=0, out_b=0, out_partial=0, pair_count=0, in_ready=1.
2. Basic pair: out_ready=1, feed 30 then 20 on consecutive cycles -> the cycle after the 2nd accept shows out_valid=1, out_a=30, out_b=20, out_partial=0; after the pop, pair_count=1 and state returns to IDLE.
3. Backpressure: out_ready=0, offer 1,2,3:
   - 1 and 2 are accepted, then in_ready=0 and 3 is held off with out_a=1, out_b=2 stable.
   - Raise out_ready -> the pair pops and 3 is accepted on the same edge; next cycle out_valid=0 and out_a=3 (HALF).
4. Flush:
   - Feed 7 then pulse flush -> out_a=7, out_b=0, out_partial=1, out_valid=1.
   - Flush pulsed in IDLE -> out_valid stays 0 and pair_count is unchanged.
5. Simultaneous accept+flush in HALF (a=5, in_data=9) -> out_a=5, out_b=9, out_partial=0, with no extra partial pair afterwards.
6. Wrap and mid-pair reset:
   - COUNT_W=4, pop 16 pairs -> pair_count returns to 0.
   - Then accept one word, assert rst_n=0 -> HALF state is lost; after release, feed 4,6 -> out_a=4, out_b=6.
